shifting_block: RTL and testbench
=================================

Name: shifting_block

Overview:
- One bit-slice (vectorisable) of the 16-bit ALU shift stage.
- Selects one of four neighbour-bit sources and registers the result:
  - A-operand from the lower neighbour (amin) or upper neighbour (aplus).
  - Carry/auxiliary chain from the lower neighbour (cmin) or upper neighbour (cplus).
- Sixteen slices, or one instance with WIDTH=16, form the ALU shift/rotate datapath. Output feeds the ALU result mux.

Parameters:
- WIDTH, 1, number of independent bit lanes. Every data port is WIDTH bits; all lanes share one select.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- amin  input  WIDTH  A bit from the lower neighbour (i-1); shift-left source
- aplus  input  WIDTH  A bit from the upper neighbour (i+1); shift-right source
- cmin  input  WIDTH  C/carry-chain bit from the lower neighbour (i-1)
- cplus  input  WIDTH  C/carry-chain bit from the upper neighbour (i+1)
- select1  input  1  select MSB
- select0  input  1  select LSB
- y  output  WIDTH  registered shifted bit(s)

Behaviour:
- Select code {select1,select0}, applied per lane:
  - 2'b00: next_y = amin
  - 2'b01: next_y = aplus
  - 2'b10: next_y = cmin
  - 2'b11: next_y = cplus
- Registered output:
  - y <= next_y on every rising clk edge where rst=0.
  - Latency is exactly 1 cycle from inputs/select to y.
  - No enable and no handshake; a new selection may be issued every cycle.
- Reset:
  - rst=1 at a rising edge forces y to all-zeros, regardless of data and select inputs.
  - Reset asserted mid-stream discards the pending selection.
  - On the first edge after rst deasserts, y takes the normal next_y.
- Select changes between edges: only the values sampled at the edge matter. There are no glitch requirements on y.
- X or Z on select at an edge: y takes X in simulation. No recovery logic is required.
- Lanes are fully independent; there is no cross-lane carry inside the block. Boundary-lane wiring (fill bit, rotate) is done by the parent.
- Purely combinational select path into a single flop stage. No internal state other than y.

Decomposition:
- Shared package alu_pkg:
  - localparams SHIFT_SEL_AMIN=2'b00, SHIFT_SEL_APLUS=2'b01, SHIFT_SEL_CMIN=2'b10, SHIFT_SEL_CPLUS=2'b11.
  - Optional typedef shift_sel_t (2-bit).
- No sub-module needed. The 4:1 select is a case statement or function inside shifting_block; the register lives in the same module.

Test Plan:
- Reset: rst=1 for 2 edges with amin=aplus=cmin=cplus=1 and sel=11 -> y=0 throughout. After the first edge with rst=0, y=1.
- Select sweep: amin=0, cmin=0, aplus=1, cplus=1; sel=00,01,10,11, each held 50 time units -> y after each edge = 0,1,0,1 respectively.
- Exclusivity: one-hot source inputs (only amin=1, then only aplus=1, and so on) across all four selects -> y=1 only when sel matches the hot source, else 0.
- Latency: change sel from 00 to 01 with amin=0, aplus=1 just after an edge -> y stays 0 until the next edge, then becomes 1.
- Mid-operation reset: sel=01, aplus=1, y=1; assert rst for one edge -> y=0. Deassert -> y=1 on the following edge.
- WIDTH=16: amin=16'hA5A5, aplus=16'h5A5A, cmin=16'hFFFF, cplus=16'h0000; sel sweep -> y=A5A5, 5A5A, FFFF, 0000 one cycle after each select.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift-stage source select encodings.
package alu_pkg;

  typedef logic [1:0] shift_sel_t;

  localparam shift_sel_t SHIFT_SEL_AMIN  = 2'b00;
  localparam shift_sel_t SHIFT_SEL_APLUS = 2'b01;
  localparam shift_sel_t SHIFT_SEL_CMIN  = 2'b10;
  localparam shift_sel_t SHIFT_SEL_CPLUS = 2'b11;

endpackage

// File: rtl/shifting_block.sv
// ALU shift-stage slice: picks one of four neighbour-bit sources per lane and registers it.
module shifting_block
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] amin,
  input  logic [WIDTH-1:0] aplus,
  input  logic [WIDTH-1:0] cmin,
  input  logic [WIDTH-1:0] cplus,
  input  logic             select1,
  input  logic             select0,
  output logic [WIDTH-1:0] y
);

  shift_sel_t       sel;
  logic [WIDTH-1:0] next_y;

  assign sel = {select1, select0};

  // Unknown select falls to the default arm so simulation propagates X to y.
  always_comb begin
    next_y = 'x;
    case (sel)
      SHIFT_SEL_AMIN:  next_y = amin;
      SHIFT_SEL_APLUS: next_y = aplus;
      SHIFT_SEL_CMIN:  next_y = cmin;
      SHIFT_SEL_CPLUS: next_y = cplus;
      default:         next_y = 'x;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else begin
      y <= next_y;
    end
  end

endmodule

// File: tb/tb_shifting_block.sv
// Directed bench for shifting_block: single-lane and 16-lane instances share clock, reset, select.
module tb_shifting_block;

  logic        clk = 1'b0;
  logic        rst;
  logic        select1, select0;
  logic        amin1, aplus1, cmin1, cplus1;
  logic        y1;
  logic [15:0] amin16, aplus16, cmin16, cplus16;
  logic [15:0] y16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shifting_block #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .amin    (amin1),
    .aplus   (aplus1),
    .cmin    (cmin1),
    .cplus   (cplus1),
    .select1 (select1),
    .select0 (select0),
    .y       (y1)
  );

  shifting_block #(.WIDTH(16)) u_dut16 (
    .clk     (clk),
    .rst     (rst),
    .amin    (amin16),
    .aplus   (aplus16),
    .cmin    (cmin16),
    .cplus   (cplus16),
    .select1 (select1),
    .select0 (select0),
    .y       (y16)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    {select1, select0} = s;
  endtask

  // Single-lane sources packed as {cplus, cmin, aplus, amin}.
  task automatic set_src1(input logic [3:0] v);
    {cplus1, cmin1, aplus1, amin1} = v;
  endtask

  initial begin
    logic [15:0] exp16 [4];
    exp16[0] = 16'hA5A5;
    exp16[1] = 16'h5A5A;
    exp16[2] = 16'hFFFF;
    exp16[3] = 16'h0000;

    rst = 1'b1;
    set_sel(2'b11);
    set_src1(4'b1111);
    amin16 = 16'hFFFF; aplus16 = 16'hFFFF; cmin16 = 16'hFFFF; cplus16 = 16'h1234;
    #2;

    // Reset held for two edges with all sources high.
    tick();
    check_val("reset_edge1_w1", {15'd0, y1}, 16'h0000);
    check_val("reset_edge1_w16", y16, 16'h0000);
    tick();
    check_val("reset_edge2_w1", {15'd0, y1}, 16'h0000);
    check_val("reset_edge2_w16", y16, 16'h0000);
    rst = 1'b0;
    tick();
    check_val("post_reset_w1", {15'd0, y1}, 16'h0001);
    check_val("post_reset_w16", y16, 16'h1234);

    // Select sweep: amin=cmin=0, aplus=cplus=1.
    set_src1(4'b1010);
    for (int s = 0; s < 4; s++) begin
      set_sel(s[1:0]);
      tick();
      check_val($sformatf("sweep_sel%0d", s), {15'd0, y1}, {15'd0, s[0]});
    end

    // One-hot source against every select.
    for (int hot = 0; hot < 4; hot++) begin
      for (int s = 0; s < 4; s++) begin
        set_src1(4'b0001 << hot);
        set_sel(s[1:0]);
        tick();
        check_val($sformatf("onehot_src%0d_sel%0d", hot, s), {15'd0, y1},
                  (hot == s) ? 16'h0001 : 16'h0000);
      end
    end

    // Latency: select change just after an edge is not visible until the next edge.
    set_src1(4'b0010);
    set_sel(2'b00);
    tick();
    check_val("latency_before", {15'd0, y1}, 16'h0000);
    set_sel(2'b01);
    #3;
    check_val("latency_between_edges", {15'd0, y1}, 16'h0000);
    tick();
    check_val("latency_after", {15'd0, y1}, 16'h0001);

    // Reset asserted mid-stream for a single edge.
    tick();
    check_val("midreset_before", {15'd0, y1}, 16'h0001);
    rst = 1'b1;
    tick();
    check_val("midreset_asserted", {15'd0, y1}, 16'h0000);
    rst = 1'b0;
    tick();
    check_val("midreset_released", {15'd0, y1}, 16'h0001);

    // 16-lane sweep.
    amin16 = 16'hA5A5; aplus16 = 16'h5A5A; cmin16 = 16'hFFFF; cplus16 = 16'h0000;
    for (int s = 0; s < 4; s++) begin
      set_sel(s[1:0]);
      tick();
      check_val($sformatf("w16_sel%0d", s), y16, exp16[s]);
    end

    // Back-to-back select changes every cycle on the wide instance.
    set_sel(2'b11);
    tick();
    set_sel(2'b00);
    tick();
    check_val("w16_b2b_amin", y16, 16'hA5A5);
    set_sel(2'b10);
    tick();
    check_val("w16_b2b_cmin", y16, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
